// File: rtl/usb_packet_transmitter_if.sv
// Request/status bundle between a host controller and the USB packet transmitter.
// DP/DM stay plain ports on the transmitter because they are tri-stated.
interface usb_packet_transmitter_if;
  logic        start;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        ready;
  logic        host_sending;
  logic        done;

  modport master (
    output start, pid, addr, endp, data,
    input  ready, host_sending, done
  );

  modport slave (
    input  start, pid, addr, endp, data,
    output ready, host_sending, done
  );
endinterface

// File: rtl/usb_packet_transmitter.sv
// Host-side USB LS/FS packet serializer: SYNC, PID, token/DATA0 payload, CRC,
// bit stuffing, NRZI and EOP onto a tri-stated DP/DM pair, one bus bit per clock.
//
// state   | meaning
// IDLE    | bus released, ready for a request
// SYNC    | sync byte, LSB first
// PID     | {~pid, pid}, LSB first
// TOKEN   | addr[0..6], endp[0..3]
// DATA    | data[0..63]
// CRC     | complemented CRC5/CRC16, MSB first (plus a trailing stuff bit if due)
// EOP1/2  | SE0
// EOP_J   | final J, done pulses in the following cycle
module usb_packet_transmitter #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         STUFF_RUN = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  usb_packet_transmitter_if.slave bus,
  output logic                   DP_out,
  output logic                   DM_out
);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam int         OW        = $clog2(STUFF_RUN + 1);
  localparam logic [OW-1:0] RUN_MAX = OW'(STUFF_RUN);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_CRC, S_EOP1, S_EOP2, S_EOP_J
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [6:0]    r_cnt, w_cnt_nxt;
  logic [OW-1:0] r_ones, w_ones_nxt;
  logic [63:0]   r_shift;
  logic [3:0]    r_pid;
  logic [4:0]    r_crc5;
  logic [15:0]   r_crc16;
  logic          r_level, r_tail, r_done;
  logic          w_pid_ok, w_accept, w_stream, w_stuff, w_adv, w_last;
  logic          w_bit, w_tx, w_level, w_tail_set, w_is_token, w_is_data;
  logic [7:0]    w_pid_byte;
  logic          w_drive, w_dp, w_dm;

  assign w_pid_ok   = bus.pid inside {PID_OUT, PID_IN, PID_DATA0, PID_ACK, PID_NAK};
  assign w_is_token = (r_pid == PID_OUT) || (r_pid == PID_IN);
  assign w_is_data  = (r_pid == PID_DATA0);
  assign w_pid_byte = {~r_pid, r_pid};

  // r_cnt counts down within a field, so ~r_cnt[2:0] walks byte fields LSB first
  assign w_stream   = r_state inside {S_SYNC, S_PID, S_TOKEN, S_DATA, S_CRC};
  assign w_stuff    = w_stream && (r_ones == RUN_MAX);
  assign w_adv      = w_stream && !w_stuff;
  assign w_last     = w_adv && (r_cnt == 7'd0);
  assign w_tx       = w_bit && !w_stuff;
  assign w_level    = w_tx ? r_level : ~r_level;
  assign w_ones_nxt = w_tx ? r_ones + 1'b1 : '0;

  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_SYNC:          w_bit = SYNC_BYTE[~r_cnt[2:0]];
      S_PID:           w_bit = w_pid_byte[~r_cnt[2:0]];
      S_TOKEN, S_DATA: w_bit = r_shift[0];
      S_CRC:           w_bit = w_is_data ? ~r_crc16[15] : ~r_crc5[4];
      default:         w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (w_adv && (r_cnt != 7'd0)) ? r_cnt - 7'd1 : r_cnt;
    w_accept    = 1'b0;
    w_tail_set  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start && w_pid_ok) begin
        w_accept    = 1'b1;
        w_state_nxt = S_SYNC;
        w_cnt_nxt   = 7'd7;
      end
      S_SYNC: if (w_last) begin
        w_state_nxt = S_PID;
        w_cnt_nxt   = 7'd7;
      end
      S_PID: if (w_last) begin
        if (w_is_token) begin
          w_state_nxt = S_TOKEN;
          w_cnt_nxt   = 7'd10;
        end else if (w_is_data) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 7'd63;
        end else begin
          w_state_nxt = S_EOP1;
        end
      end
      S_TOKEN: if (w_last) begin
        w_state_nxt = S_CRC;
        w_cnt_nxt   = 7'd4;
      end
      S_DATA: if (w_last) begin
        w_state_nxt = S_CRC;
        w_cnt_nxt   = 7'd15;
      end
      // a run completed by the last CRC bit still owes its stuffed 0 before EOP
      S_CRC: begin
        if (w_stuff && r_tail) begin
          w_state_nxt = S_EOP1;
        end else if (w_last) begin
          if (w_ones_nxt == RUN_MAX) w_tail_set  = 1'b1;
          else                       w_state_nxt = S_EOP1;
        end
      end
      S_EOP1:  w_state_nxt = S_EOP2;
      S_EOP2:  w_state_nxt = S_EOP_J;
      S_EOP_J: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_drive = 1'b1;
    w_dp    = w_level;
    w_dm    = ~w_level;
    case (r_state)
      S_IDLE: begin
        w_drive = 1'b0;
        w_dp    = 1'b0;
        w_dm    = 1'b0;
      end
      S_EOP1, S_EOP2: begin
        w_dp = 1'b0;
        w_dm = 1'b0;
      end
      S_EOP_J: begin
        w_dp = 1'b1;
        w_dm = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ones  <= '0;
      r_shift <= '0;
      r_pid   <= '0;
      r_crc5  <= '1;
      r_crc16 <= '1;
      r_level <= 1'b1;
      r_tail  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ones <= w_stream ? w_ones_nxt : '0;
      r_level <= w_stream ? w_level : 1'b1;
      r_tail <= w_tail_set || (r_tail && (w_state_nxt == S_CRC));
      r_done <= (r_state == S_EOP_J);
      if (w_accept) begin
        r_pid   <= bus.pid;
        r_shift <= (bus.pid == PID_DATA0) ? bus.data : {53'd0, bus.endp, bus.addr};
        r_crc5  <= '1;
        r_crc16 <= '1;
      end else if (w_adv) begin
        case (r_state)
          S_TOKEN: begin
            r_shift <= r_shift >> 1;
            r_crc5  <= {r_crc5[3:0], 1'b0} ^ ((r_crc5[4] ^ r_shift[0]) ? 5'h05 : 5'h00);
          end
          S_DATA: begin
            r_shift <= r_shift >> 1;
            r_crc16 <= {r_crc16[14:0], 1'b0} ^ ((r_crc16[15] ^ r_shift[0]) ? 16'h8005 : 16'h0000);
          end
          S_CRC: begin
            r_crc5  <= {r_crc5[3:0], 1'b0};
            r_crc16 <= {r_crc16[14:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ready        = (r_state == S_IDLE);
  assign bus.host_sending = w_drive;
  assign bus.done         = r_done;
  assign DP_out           = w_drive ? w_dp : 1'bz;
  assign DM_out           = w_drive ? w_dm : 1'bz;
endmodule

// File: tb/tb_usb_packet_transmitter.sv
// Directed bench for usb_packet_transmitter: a vector table of packets compared
// against a bit-stream model and a wire decoder, plus reset/busy/bad-PID sequences.
module tb_usb_packet_transmitter;
  localparam logic [1:0] L_J = 2'b10, L_K = 2'b01, L_SE0 = 2'b00;
  localparam logic [3:0] PID_OUT = 4'b0001, PID_IN = 4'b1001, PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    int          exp_len;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic DP_out, DM_out;
  int   errors = 0;
  int   checks = 0;

  usb_packet_transmitter_if bus();
  usb_packet_transmitter dut (
    .clock(clock), .reset(reset), .bus(bus), .DP_out(DP_out), .DM_out(DM_out)
  );

  always #5 clock = ~clock;

  bit         raw_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];
  bit         dec_q[$];
  int         last_n, dec_stuffs, dec_pre_crc, dec_bad, dec_maxrun;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_bits(input logic [63:0] v, input int nb);
    for (int i = 0; i < nb; i++) raw_q.push_back(v[i]);
  endfunction

  function automatic logic [15:0] crc_of(input int from, input int cnt, input int w, input logic [15:0] poly);
    logic [15:0] c    = 16'hFFFF;
    logic [15:0] mask = 16'((32'd1 << w) - 1);
    logic fb;
    for (int i = 0; i < cnt; i++) begin
      fb = c[w-1] ^ raw_q[from+i];
      c  = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    return ~c & mask;
  endfunction

  function automatic void build_model(input vec_t v);
    logic [15:0] crc;
    int ones = 0;
    bit lvl  = 1'b1;
    raw_q.delete();
    exp_q.delete();
    push_bits(64'h80, 8);
    push_bits({56'd0, ~v.pid, v.pid}, 8);
    if (v.pid == PID_OUT || v.pid == PID_IN) begin
      push_bits({57'd0, v.addr}, 7);
      push_bits({60'd0, v.endp}, 4);
      crc = crc_of(16, 11, 5, 16'h0005);
      for (int i = 4; i >= 0; i--) raw_q.push_back(crc[i]);
    end else if (v.pid == PID_DATA0) begin
      push_bits(v.data, 64);
      crc = crc_of(16, 64, 16, 16'h8005);
      for (int i = 15; i >= 0; i--) raw_q.push_back(crc[i]);
    end
    foreach (raw_q[i]) begin
      if (!raw_q[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? L_J : L_K);
      ones = raw_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_q.push_back(lvl ? L_J : L_K);
        ones = 0;
      end
    end
    exp_q.push_back(L_SE0);
    exp_q.push_back(L_SE0);
    exp_q.push_back(L_J);
  endfunction

  // NRZI-decode and de-stuff what was captured off the wire
  function automatic void decode();
    int  n    = cap_q.size() - 3;
    int  ones = 0;
    int  run  = 0;
    bit  prev = 1'b1;
    bit  lvl, b;
    dec_q.delete();
    dec_stuffs = 0; dec_pre_crc = 0; dec_bad = 0; dec_maxrun = 0;
    for (int i = 0; i < n; i++) begin
      lvl = (cap_q[i] == L_J);
      b   = (lvl == prev);
      prev = lvl;
      run = (i > 0 && cap_q[i] == cap_q[i-1]) ? run + 1 : 1;
      if (run > dec_maxrun) dec_maxrun = run;
      if (ones == 6) begin
        dec_stuffs++;
        if (dec_q.size() <= 80) dec_pre_crc++;
        if (b) dec_bad++;
        ones = 0;
      end else begin
        dec_q.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
  endfunction

  task automatic run_packet(input vec_t v, input bit poke, input int idx);
    int n = 0;
    int dones = 0;
    int mism = 0;
    build_model(v);
    check($sformatf("v%0d_ready_before", idx), int'(bus.ready), 1);
    bus.pid = v.pid; bus.addr = v.addr; bus.endp = v.endp; bus.data = v.data;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.pid = ~v.pid; bus.addr = ~v.addr; bus.endp = ~v.endp; bus.data = {$urandom, $urandom};
    cap_q.delete();
    while (bus.host_sending === 1'b1 && n < 400) begin
      cap_q.push_back({DP_out, DM_out});
      if (bus.done === 1'b1) dones++;
      bus.start = poke && (n == 20);
      if (poke && n == 20) bus.pid = PID_ACK;
      n++;
      cyc();
    end
    bus.start = 1'b0;
    last_n = n;
    check($sformatf("v%0d_no_timeout", idx), int'(n < 400), 1);
    check($sformatf("v%0d_len_vs_model", idx), n, exp_q.size());
    if (v.exp_len > 0) check($sformatf("v%0d_len_hand", idx), n, v.exp_len);
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) mism++;
    check($sformatf("v%0d_wire_mismatches", idx), mism, 0);
    check($sformatf("v%0d_done_while_busy", idx), dones, 0);
    check($sformatf("v%0d_done_pulse", idx), int'(bus.done), 1);
    check($sformatf("v%0d_ready_after", idx), int'(bus.ready), 1);
    decode();
    mism = 0;
    for (int i = 0; i < raw_q.size(); i++)
      if (i >= dec_q.size() || dec_q[i] != raw_q[i]) mism++;
    check($sformatf("v%0d_decoded_bits", idx), mism + (dec_q.size() != raw_q.size()), 0);
    check($sformatf("v%0d_stuff_bit_zero", idx), dec_bad, 0);
    check($sformatf("v%0d_level_run_le7", idx), int'(dec_maxrun <= 7), 1);
  endtask

  vec_t vecs[7];
  int   viol;
  logic [4:0] crc_obs;

  initial begin
    vecs[0] = '{PID_ACK,   7'h00, 4'h0, 64'h0, 19};
    vecs[1] = '{PID_NAK,   7'h00, 4'h0, 64'h0, 19};
    vecs[2] = '{PID_OUT,   7'h15, 4'hE, 64'h0, 35};
    vecs[3] = '{PID_IN,    7'h7F, 4'hF, 64'h0, 36};
    vecs[4] = '{PID_DATA0, 7'h00, 4'h0, 64'h0, 0};
    vecs[5] = '{PID_DATA0, 7'h00, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[6] = '{PID_DATA0, 7'h00, 4'h0, 64'hA5A5_0F0F_3C3C_FF00, 0};

    bus.start = 1'b0; bus.pid = '0; bus.addr = '0; bus.endp = '0; bus.data = '0;
    repeat (2) cyc();
    check("rst_ready", int'(bus.ready), 1);
    check("rst_host_sending", int'(bus.host_sending), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_dp_released", int'(DP_out !== 1'b1), 1);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      run_packet(vecs[i], 1'b0, i);
      if (i == 2) begin
        check("out_stuffs", dec_stuffs, 0);
        for (int k = 0; k < 5; k++) crc_obs[4-k] = dec_q[27+k];
        check("out_crc5", int'(crc_obs), int'(5'b10111));
      end
      if (i == 5) begin
        check("ones_stuffs_before_crc", dec_pre_crc, 11);
        check("ones_len_99_plus_stuffs", last_n, 99 + dec_stuffs);
      end
    end

    // start while busy must be ignored
    run_packet(vecs[6], 1'b1, 7);
    viol = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.done !== 1'b0 || bus.host_sending !== 1'b0) viol++;
    end
    check("busy_start_ignored", viol, 0);

    // reset at payload bit 30 of a DATA0 packet
    bus.pid = PID_DATA0; bus.data = 64'h0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (46) cyc();
    check("pre_reset_sending", int'(bus.host_sending), 1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_host_sending", int'(bus.host_sending), 0);
    check("mid_rst_ready", int'(bus.ready), 1);
    check("mid_rst_dp_released", int'(DP_out !== 1'b1), 1);
    #2 reset = 1'b0;
    cyc();
    viol = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.done !== 1'b0 || bus.host_sending !== 1'b0) viol++;
      cyc();
    end
    check("mid_rst_no_done", viol, 0);
    run_packet(vecs[0], 1'b0, 8);

    // unsupported PID
    cyc();
    bus.pid = 4'b0111; bus.start = 1'b1;
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.start = 1'b0;
      if (bus.host_sending !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) viol++;
    end
    check("bad_pid_ignored", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
